// File: rtl/video_pattern_gen.sv
// Raster timing generator (vs/hs/de) with a selectable 24-bit RGB test pattern.
// All outputs registered; bus packing is R[23:16], G[15:8], B[7:0].
module video_pattern_gen #(
   parameter int   H_ACTIVE = 1280,
   parameter int   H_FP     = 110,
   parameter int   H_SYNC   = 40,
   parameter int   H_BP     = 220,
   parameter int   V_ACTIVE = 720,
   parameter int   V_FP     = 5,
   parameter int   V_SYNC   = 5,
   parameter int   V_BP     = 20,
   parameter logic HS_POL   = 1'b1,
   parameter logic VS_POL   = 1'b1
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic        en,
   input  logic [1:0]  pat_sel,
   output logic        vs_out,
   output logic        hs_out,
   output logic        de_out,
   output logic [23:0] rgb_data_out
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL + 1);
   localparam int VW      = $clog2(V_TOTAL + 1);
   localparam int BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
   localparam int BPW     = $clog2(BAR_W + 1);

   localparam logic [HW-1:0]  H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0]  H_ACT    = HW'(H_ACTIVE);
   localparam logic [HW-1:0]  HS_START = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0]  HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0]  V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0]  V_ACT    = VW'(V_ACTIVE);
   localparam logic [VW-1:0]  VS_START = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0]  VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [BPW-1:0] BAR_LAST = BPW'(BAR_W - 1);

   logic [HW-1:0]  h_cnt_reg, h_cnt_next;
   logic [VW-1:0]  v_cnt_reg, v_cnt_next;
   logic [7:0]     frame_cnt_reg, frame_cnt_next;
   logic [1:0]     pat_reg, pat_eff;
   logic [2:0]     bar_idx_reg, bar_idx_next;
   logic [BPW-1:0] bar_pix_reg, bar_pix_next;
   logic           de_next, hs_next, vs_next;
   logic [23:0]    rgb_next, pix_rgb, bar_rgb;
   logic [7:0]     h_lo;
   logic           at_origin, h_last, v_last, active, checker_on;

   always_comb begin
      at_origin  = (h_cnt_reg == '0) && (v_cnt_reg == '0);
      // The frame's first pixel already uses the freshly sampled selection.
      pat_eff    = at_origin ? pat_sel : pat_reg;
      h_lo       = 8'(h_cnt_reg);
      checker_on = ((32'(h_cnt_reg) ^ 32'(v_cnt_reg)) & 32'd32) != 32'd0;
      active     = (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT);
      de_next    = active;
      hs_next    = ((h_cnt_reg >= HS_START) && (h_cnt_reg < HS_END)) ? HS_POL : ~HS_POL;
      vs_next    = ((v_cnt_reg >= VS_START) && (v_cnt_reg < VS_END)) ? VS_POL : ~VS_POL;

      case (bar_idx_reg)
         3'd0:    bar_rgb = 24'hFFFFFF;
         3'd1:    bar_rgb = 24'hFFFF00;
         3'd2:    bar_rgb = 24'h00FFFF;
         3'd3:    bar_rgb = 24'h00FF00;
         3'd4:    bar_rgb = 24'hFF00FF;
         3'd5:    bar_rgb = 24'hFF0000;
         3'd6:    bar_rgb = 24'h0000FF;
         default: bar_rgb = 24'h000000;
      endcase

      case (pat_eff)
         2'd0:    pix_rgb = bar_rgb;
         2'd1:    pix_rgb = {3{h_lo}};
         2'd2:    pix_rgb = checker_on ? 24'hFFFFFF : 24'h000000;
         default: pix_rgb = {3{h_lo + frame_cnt_reg}};
      endcase
      rgb_next = active ? pix_rgb : 24'h000000;

      h_last         = (h_cnt_reg == H_LAST);
      v_last         = (v_cnt_reg == V_LAST);
      h_cnt_next     = h_last ? '0 : h_cnt_reg + 1'b1;
      v_cnt_next     = v_cnt_reg;
      frame_cnt_next = frame_cnt_reg;
      if (h_last) begin
         v_cnt_next = v_last ? '0 : v_cnt_reg + 1'b1;
         if (v_last) frame_cnt_next = frame_cnt_reg + 1'b1;
      end

      // Bar index tracks h_cnt by counting pixels within the bar; stays at 7 past the last bar.
      bar_idx_next = bar_idx_reg;
      bar_pix_next = bar_pix_reg + 1'b1;
      if (h_last) begin
         bar_idx_next = '0;
         bar_pix_next = '0;
      end else if (bar_pix_reg == BAR_LAST) begin
         bar_pix_next = '0;
         if (bar_idx_reg != 3'd7) bar_idx_next = bar_idx_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         h_cnt_reg     <= '0;
         v_cnt_reg     <= '0;
         frame_cnt_reg <= '0;
         pat_reg       <= '0;
         bar_idx_reg   <= '0;
         bar_pix_reg   <= '0;
         de_out        <= 1'b0;
         hs_out        <= ~HS_POL;
         vs_out        <= ~VS_POL;
         rgb_data_out  <= '0;
      end else if (!en) begin
         h_cnt_reg     <= '0;
         v_cnt_reg     <= '0;
         bar_idx_reg   <= '0;
         bar_pix_reg   <= '0;
         de_out        <= 1'b0;
         hs_out        <= ~HS_POL;
         vs_out        <= ~VS_POL;
         rgb_data_out  <= '0;
      end else begin
         h_cnt_reg     <= h_cnt_next;
         v_cnt_reg     <= v_cnt_next;
         frame_cnt_reg <= frame_cnt_next;
         if (at_origin) pat_reg <= pat_sel;
         bar_idx_reg   <= bar_idx_next;
         bar_pix_reg   <= bar_pix_next;
         de_out        <= de_next;
         hs_out        <= hs_next;
         vs_out        <= vs_next;
         rgb_data_out  <= rgb_next;
      end
   end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench for video_pattern_gen on a 22x7 raster: a reference model queues the
// expected output of every edge, a monitor compares; directed checks pin hand-derived pixels.
module tb_video_pattern_gen;

   localparam int HA = 16, HFP = 2, HSY = 2, HBP = 2;
   localparam int VA = 4, VFP = 1, VSY = 1, VBP = 1;
   localparam int HT = HA + HFP + HSY + HBP;
   localparam int VT = VA + VFP + VSY + VBP;

   logic        clk = 1'b0;
   logic        rst_b = 1'b0;
   logic        en = 1'b0;
   logic [1:0]  pat_sel = 2'd0;
   logic        vs_out, hs_out, de_out;
   logic [23:0] rgb_data_out;

   video_pattern_gen #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .HS_POL(1'b1), .VS_POL(1'b1)
   ) dut (
      .clk(clk), .rst_b(rst_b), .en(en), .pat_sel(pat_sel),
      .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out), .rgb_data_out(rgb_data_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [26:0] exp;   // {de, hs, vs, rgb}
      int          h;
      int          v;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          failures = 0;
   int          m_h = 0;
   int          m_v = 0;
   logic [7:0]  m_frame = 8'd0;
   logic [1:0]  m_pat = 2'd0;
   logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   function automatic logic [23:0] pixel(int h, int v, logic [1:0] p, logic [7:0] f);
      int         idx;
      logic [7:0] b;
      b = h[7:0];
      case (p)
         2'd0: begin
            idx = h / (HA / 8);
            if (idx > 7) idx = 7;
            return bars[idx];
         end
         2'd1: return {3{b}};
         2'd2: return ((((h >> 5) ^ (v >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
         default: begin
            b = b + f;
            return {3{b}};
         end
      endcase
   endfunction

   // Reference model: one expectation per clock edge
   initial begin
      exp_t       e;
      logic [1:0] p;
      logic       de, hs, vs;
      forever begin
         @(posedge clk);
         e.h = m_h;
         e.v = m_v;
         if (!rst_b || !en) begin
            e.exp = 27'd0;
            m_h = 0;
            m_v = 0;
            if (!rst_b) begin
               m_frame = 8'd0;
               m_pat   = 2'd0;
            end
         end else begin
            p = (m_h == 0 && m_v == 0) ? pat_sel : m_pat;
            m_pat = p;
            de = (m_h < HA) && (m_v < VA);
            hs = (m_h >= HA + HFP) && (m_h < HA + HFP + HSY);
            vs = (m_v >= VA + VFP) && (m_v < VA + VFP + VSY);
            e.exp = {de, hs, vs, de ? pixel(m_h, m_v, p, m_frame) : 24'h000000};
            m_h = m_h + 1;
            if (m_h == HT) begin
               m_h = 0;
               m_v = m_v + 1;
               if (m_v == VT) begin
                  m_v = 0;
                  m_frame = m_frame + 8'd1;
               end
            end
         end
         q.push_back(e);
      end
   end

   // Monitor: the DUT presents a new output every clock
   initial begin
      exp_t        e;
      logic [26:0] got;
      forever begin
         @(posedge clk);
         #2;
         checks++;
         got = {de_out, hs_out, vs_out, rgb_data_out};
         if (q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty got=%h required=expectation", got);
         end else begin
            e = q.pop_front();
            if (got !== e.exp) begin
               failures++;
               $display("FAIL stream h=%0d v=%0d got {de,hs,vs,rgb}=%h required=%h",
                        e.h, e.v, got, e.exp);
            end
         end
      end
   end

   task automatic check(input string name, input logic [26:0] exp);
      logic [26:0] got;
      got = {de_out, hs_out, vs_out, rgb_data_out};
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got {de,hs,vs,rgb}=%h required=%h", name, got, exp);
      end
   endtask

   // Returns at a negedge where the next edge samples (h,v)
   task automatic wait_pos(input int h, input int v);
      int n;
      n = 0;
      @(negedge clk);
      while (!(m_h == h && m_v == v)) begin
         if (n > 400) begin
            checks++;
            failures++;
            $display("FAIL wait_pos timeout got=(%0d,%0d) required=(%0d,%0d)", m_h, m_v, h, v);
            return;
         end
         @(negedge clk);
         n++;
      end
   endtask

   task automatic sample_at(input string name, input int h, input int v, input logic [26:0] exp);
      wait_pos(h, v);
      @(posedge clk);
      #3;
      check(name, exp);
   endtask

   typedef struct {
      int          h;
      int          v;
      logic [26:0] exp;
   } vec_t;

   vec_t frame_vecs [14] = '{
      '{2,  0, {3'b100, 24'hFFFF00}}, '{5,  0, {3'b100, 24'h00FFFF}},
      '{10, 0, {3'b100, 24'hFF0000}}, '{13, 1, {3'b100, 24'h0000FF}},
      '{15, 3, {3'b100, 24'h000000}}, '{16, 3, {3'b000, 24'h000000}},
      '{18, 3, {3'b010, 24'h000000}}, '{19, 3, {3'b010, 24'h000000}},
      '{20, 3, {3'b000, 24'h000000}}, '{3,  4, {3'b000, 24'h000000}},
      '{0,  5, {3'b001, 24'h000000}}, '{19, 5, {3'b011, 24'h000000}},
      '{21, 5, {3'b001, 24'h000000}}, '{0,  6, {3'b000, 24'h000000}}
   };

   initial begin
      logic [7:0] fb;
      repeat (3) @(negedge clk);
      check("reset_state", 27'd0);

      // Bars frame with full raster timing
      rst_b   = 1'b1;
      en      = 1'b1;
      pat_sel = 2'd0;
      @(posedge clk);
      #3;
      check("first_pixel_bar0", {3'b100, 24'hFFFFFF});
      foreach (frame_vecs[i])
         sample_at($sformatf("frame_vec%0d", i), frame_vecs[i].h, frame_vecs[i].v, frame_vecs[i].exp);

      // Mid-frame pattern change lands on the next frame
      wait_pos(5, 2);
      pat_sel = 2'd2;
      sample_at("no_tear_bar3", 6, 2, {3'b100, 24'h00FF00});
      sample_at("checker_origin", 0, 0, {3'b100, 24'h000000});
      sample_at("checker_px7", 7, 0, {3'b100, 24'h000000});

      // en drop mid-line, then restart at origin
      pat_sel = 2'd0;
      sample_at("bars_back", 0, 0, {3'b100, 24'hFFFFFF});
      wait_pos(7, 1);
      en = 1'b0;
      @(posedge clk);
      #3;
      check("en_low_idle", 27'd0);
      repeat (4) @(negedge clk);
      en = 1'b1;
      @(posedge clk);
      #3;
      check("en_restart_origin", {3'b100, 24'hFFFFFF});
      sample_at("restart_hs", 19, 0, {3'b010, 24'h000000});
      sample_at("restart_vs", 0, 5, {3'b001, 24'h000000});

      // Asynchronous reset during sync
      sample_at("pre_reset_sync", 18, 5, {3'b011, 24'h000000});
      @(negedge clk);
      rst_b = 1'b0;
      #1;
      check("async_reset_immediate", 27'd0);
      repeat (3) @(negedge clk);
      rst_b = 1'b1;
      @(posedge clk);
      #3;
      check("post_reset_origin", {3'b100, 24'hFFFFFF});

      // Scrolling ramp: frame_cnt restarted at 0, so frame n pixel 0 is n mod 256
      pat_sel = 2'd3;
      for (int f = 1; f <= 256; f++) begin
         wait_pos(0, 0);
         @(posedge clk);
         #3;
         if (f == 1 || f == 128 || f == 255 || f == 256) begin
            fb = 8'(f);
            check($sformatf("scroll_frame%0d_px0", f), {3'b100, {3{fb}}});
         end
      end
      sample_at("scroll_frame256_px15", 15, 0, {3'b100, 24'h0F0F0F});

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
